// File: rtl/axi4_arbiter_2to1_if.sv
// AXI4 port bundle (id 4, addr 32, data 64) shared by the arbiter's
// requester-facing and slave-facing sides.
interface axi4_arbiter_2to1_if;
    logic        arvalid;
    logic        arready;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;

    logic        rvalid;
    logic        rready;
    logic [3:0]  rid;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;

    logic        awvalid;
    logic        awready;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;

    logic        wvalid;
    logic        wready;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        wlast;

    logic        bvalid;
    logic        bready;
    logic [3:0]  bid;
    logic [1:0]  bresp;

    modport master (
        output arvalid, arid, araddr, arlen, arsize, arburst,
        input  arready,
        input  rvalid, rid, rdata, rresp, rlast,
        output rready,
        output awvalid, awid, awaddr, awlen, awsize, awburst,
        input  awready,
        output wvalid, wdata, wstrb, wlast,
        input  wready,
        input  bvalid, bid, bresp,
        output bready
    );

    modport slave (
        input  arvalid, arid, araddr, arlen, arsize, arburst,
        output arready,
        output rvalid, rid, rdata, rresp, rlast,
        input  rready,
        input  awvalid, awid, awaddr, awlen, awsize, awburst,
        output awready,
        input  wvalid, wdata, wstrb, wlast,
        output wready,
        output bvalid, bid, bresp,
        input  bready
    );
endinterface

// File: rtl/axi4_arbiter_2to1.sv
// Two-requester round-robin AXI4 arbiter, one transaction in flight;
// payloads pass through, only valid/ready steering is sequenced.
module axi4_arbiter_2to1 (
    input  logic                 clock,
    input  logic                 reset,
    axi4_arbiter_2to1_if.slave   in0,
    axi4_arbiter_2to1_if.slave   in1,
    axi4_arbiter_2to1_if.master  out
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        AR   = 3'd1,
        R    = 3'd2,
        AW   = 3'd3,
        W    = 3'd4,
        B    = 3'd5
    } state_e;

    state_e state_q, state_d;
    logic   grant_q, grant_d;
    logic   last_q, last_d;

    logic req0, req1, pick, pick_rd;
    logic st_ar, st_r, st_aw, st_w, st_b;
    logic g0, g1;

    logic        s_arvalid, s_awvalid, s_wvalid, s_wlast;
    logic        s_rready, s_bready;
    logic [3:0]  s_arid, s_awid;
    logic [31:0] s_araddr, s_awaddr;
    logic [7:0]  s_arlen, s_awlen, s_wstrb;
    logic [2:0]  s_arsize, s_awsize;
    logic [1:0]  s_arburst, s_awburst;
    logic [63:0] s_wdata;

    assign req0 = in0.arvalid | in0.awvalid;
    assign req1 = in1.arvalid | in1.awvalid;

    assign st_ar = (state_q == AR);
    assign st_r  = (state_q == R);
    assign st_aw = (state_q == AW);
    assign st_w  = (state_q == W);
    assign st_b  = (state_q == B);
    assign g0    = ~grant_q;
    assign g1    = grant_q;

    // Granted requester's inputs, before channel gating
    assign s_arvalid = g1 ? in1.arvalid : in0.arvalid;
    assign s_arid    = g1 ? in1.arid    : in0.arid;
    assign s_araddr  = g1 ? in1.araddr  : in0.araddr;
    assign s_arlen   = g1 ? in1.arlen   : in0.arlen;
    assign s_arsize  = g1 ? in1.arsize  : in0.arsize;
    assign s_arburst = g1 ? in1.arburst : in0.arburst;
    assign s_rready  = g1 ? in1.rready  : in0.rready;
    assign s_awvalid = g1 ? in1.awvalid : in0.awvalid;
    assign s_awid    = g1 ? in1.awid    : in0.awid;
    assign s_awaddr  = g1 ? in1.awaddr  : in0.awaddr;
    assign s_awlen   = g1 ? in1.awlen   : in0.awlen;
    assign s_awsize  = g1 ? in1.awsize  : in0.awsize;
    assign s_awburst = g1 ? in1.awburst : in0.awburst;
    assign s_wvalid  = g1 ? in1.wvalid  : in0.wvalid;
    assign s_wdata   = g1 ? in1.wdata   : in0.wdata;
    assign s_wstrb   = g1 ? in1.wstrb   : in0.wstrb;
    assign s_wlast   = g1 ? in1.wlast   : in0.wlast;
    assign s_bready  = g1 ? in1.bready  : in0.bready;

    assign out.arvalid = st_ar & s_arvalid;
    assign out.arid    = st_ar ? s_arid    : '0;
    assign out.araddr  = st_ar ? s_araddr  : '0;
    assign out.arlen   = st_ar ? s_arlen   : '0;
    assign out.arsize  = st_ar ? s_arsize  : '0;
    assign out.arburst = st_ar ? s_arburst : '0;
    assign out.rready  = st_r & s_rready;
    assign out.awvalid = st_aw & s_awvalid;
    assign out.awid    = st_aw ? s_awid    : '0;
    assign out.awaddr  = st_aw ? s_awaddr  : '0;
    assign out.awlen   = st_aw ? s_awlen   : '0;
    assign out.awsize  = st_aw ? s_awsize  : '0;
    assign out.awburst = st_aw ? s_awburst : '0;
    assign out.wvalid  = st_w & s_wvalid;
    assign out.wdata   = st_w ? s_wdata : '0;
    assign out.wstrb   = st_w ? s_wstrb : '0;
    assign out.wlast   = st_w & s_wlast;
    assign out.bready  = st_b & s_bready;

    assign in0.arready = st_ar & g0 & out.arready;
    assign in0.rvalid  = st_r & g0 & out.rvalid;
    assign in0.rid     = (st_r & g0) ? out.rid   : '0;
    assign in0.rdata   = (st_r & g0) ? out.rdata : '0;
    assign in0.rresp   = (st_r & g0) ? out.rresp : '0;
    assign in0.rlast   = st_r & g0 & out.rlast;
    assign in0.awready = st_aw & g0 & out.awready;
    assign in0.wready  = st_w & g0 & out.wready;
    assign in0.bvalid  = st_b & g0 & out.bvalid;
    assign in0.bid     = (st_b & g0) ? out.bid   : '0;
    assign in0.bresp   = (st_b & g0) ? out.bresp : '0;

    assign in1.arready = st_ar & g1 & out.arready;
    assign in1.rvalid  = st_r & g1 & out.rvalid;
    assign in1.rid     = (st_r & g1) ? out.rid   : '0;
    assign in1.rdata   = (st_r & g1) ? out.rdata : '0;
    assign in1.rresp   = (st_r & g1) ? out.rresp : '0;
    assign in1.rlast   = st_r & g1 & out.rlast;
    assign in1.awready = st_aw & g1 & out.awready;
    assign in1.wready  = st_w & g1 & out.wready;
    assign in1.bvalid  = st_b & g1 & out.bvalid;
    assign in1.bid     = (st_b & g1) ? out.bid   : '0;
    assign in1.bresp   = (st_b & g1) ? out.bresp : '0;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        pick    = 1'b0;
        pick_rd = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req0 | req1) begin
                    // Contention goes to whoever did not finish last
                    pick    = (req0 & req1) ? ~last_q : req1;
                    pick_rd = pick ? in1.arvalid : in0.arvalid;
                    grant_d = pick;
                    state_d = pick_rd ? AR : AW;
                end
            end
            AR: begin
                if (s_arvalid & out.arready)
                    state_d = R;
            end
            R: begin
                if (out.rvalid & s_rready & out.rlast) begin
                    state_d = IDLE;
                    last_d  = grant_q;
                end
            end
            AW: begin
                if (s_awvalid & out.awready)
                    state_d = W;
            end
            W: begin
                if (s_wvalid & out.wready & s_wlast)
                    state_d = B;
            end
            B: begin
                if (out.bvalid & s_bready) begin
                    state_d = IDLE;
                    last_d  = grant_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: tb/tb_axi4_arbiter_2to1.sv
// Directed bench for axi4_arbiter_2to1: reads, writes, contention,
// backpressure and mid-burst reset.
module tb_axi4_arbiter_2to1;
  logic clock;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  axi4_arbiter_2to1_if in0_if ();
  axi4_arbiter_2to1_if in1_if ();
  axi4_arbiter_2to1_if out_if ();

  axi4_arbiter_2to1 dut (
    .clock (clock),
    .reset (reset),
    .in0   (in0_if),
    .in1   (in1_if),
    .out   (out_if)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input bit ok);
    checks++;
    if (!ok) begin
      failures++;
      $error("FAIL %s", tag);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clr();
    in0_if.arvalid = 0; in0_if.arid = 0; in0_if.araddr = 0;
    in0_if.arlen = 0; in0_if.arsize = 0; in0_if.arburst = 0;
    in0_if.rready = 0;
    in0_if.awvalid = 0; in0_if.awid = 0; in0_if.awaddr = 0;
    in0_if.awlen = 0; in0_if.awsize = 0; in0_if.awburst = 0;
    in0_if.wvalid = 0; in0_if.wdata = 0; in0_if.wstrb = 0;
    in0_if.wlast = 0; in0_if.bready = 0;
    in1_if.arvalid = 0; in1_if.arid = 0; in1_if.araddr = 0;
    in1_if.arlen = 0; in1_if.arsize = 0; in1_if.arburst = 0;
    in1_if.rready = 0;
    in1_if.awvalid = 0; in1_if.awid = 0; in1_if.awaddr = 0;
    in1_if.awlen = 0; in1_if.awsize = 0; in1_if.awburst = 0;
    in1_if.wvalid = 0; in1_if.wdata = 0; in1_if.wstrb = 0;
    in1_if.wlast = 0; in1_if.bready = 0;
    out_if.arready = 0; out_if.awready = 0; out_if.wready = 0;
    out_if.rvalid = 0; out_if.rid = 0; out_if.rdata = 0;
    out_if.rresp = 0; out_if.rlast = 0;
    out_if.bvalid = 0; out_if.bid = 0; out_if.bresp = 0;
  endtask

  logic rv_v [9] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
  logic rr_v [9] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

  initial begin
    int k;
    reset = 0;
    clr();
    step();
    step();
    reset = 1;
    #1;
    chk("rst_state", dut.state_q === 3'd0);
    chk("rst_grant", dut.grant_q === 1'b0);
    chk("rst_last", dut.last_q === 1'b1);
    chk("rst_out_arvalid", out_if.arvalid === 1'b0);
    chk("rst_in0_arready", in0_if.arready === 1'b0);

    in0_if.arvalid = 1; in0_if.araddr = 32'h8000_0000;
    in0_if.arlen = 3; in0_if.arid = 4'h5;
    in0_if.arsize = 3; in0_if.arburst = 1;
    #1;
    chk("t1_pre_arvalid", out_if.arvalid === 1'b0);
    step();
    chk("t1_arvalid", out_if.arvalid === 1'b1);
    chk("t1_araddr", out_if.araddr === 32'h8000_0000);
    chk("t1_arlen", out_if.arlen === 8'd3);
    chk("t1_in1_arready", in1_if.arready === 1'b0);
    out_if.arready = 1;
    #1;
    chk("t1_in0_arready", in0_if.arready === 1'b1);
    step();
    in0_if.arvalid = 0; out_if.arready = 0; in0_if.rready = 1;
    for (int i = 0; i < 4; i++) begin
      out_if.rvalid = 1; out_if.rid = 4'h5;
      out_if.rdata = 64'h11 * (i + 1);
      out_if.rlast = (i == 3);
      #1;
      chk("t1_rvalid", in0_if.rvalid === 1'b1);
      chk("t1_rdata", in0_if.rdata === 64'h11 * (i + 1));
      chk("t1_rlast", in0_if.rlast === (i == 3));
      chk("t1_in1_rvalid", in1_if.rvalid === 1'b0);
      step();
    end
    out_if.rvalid = 0; out_if.rlast = 0;
    #1;
    chk("t1_idle", dut.state_q === 3'd0);
    chk("t1_last", dut.last_q === 1'b0);

    reset = 0; clr(); step(); reset = 1;
    in0_if.arvalid = 1; in0_if.araddr = 32'h1000_0000;
    in1_if.arvalid = 1; in1_if.araddr = 32'h2000_0000;
    in0_if.rready = 1; in1_if.rready = 1;
    out_if.arready = 1;
    #1;
    chk("t2_idle_arvalid", out_if.arvalid === 1'b0);
    step();
    chk("t2_first_addr", out_if.araddr === 32'h1000_0000);
    chk("t2_in1_arready", in1_if.arready === 1'b0);
    chk("t2_in0_arready", in0_if.arready === 1'b1);
    step();
    in0_if.arvalid = 0;
    out_if.rvalid = 1; out_if.rlast = 1; out_if.rdata = 64'hAA;
    #1;
    chk("t2_in0_rdata", in0_if.rdata === 64'hAA);
    chk("t2_in1_rvalid", in1_if.rvalid === 1'b0);
    step();
    out_if.rvalid = 0;
    #1;
    chk("t2_gap_arvalid", out_if.arvalid === 1'b0);
    step();
    chk("t2_second_addr", out_if.araddr === 32'h2000_0000);
    chk("t2_in1_arready2", in1_if.arready === 1'b1);
    step();
    in1_if.arvalid = 0;
    out_if.rvalid = 1; out_if.rdata = 64'hBB;
    #1;
    chk("t2_in1_rdata", in1_if.rdata === 64'hBB);
    chk("t2_in0_rvalid", in0_if.rvalid === 1'b0);
    step();
    out_if.rvalid = 0;
    in0_if.arvalid = 1; in1_if.arvalid = 1;
    step();
    chk("t2_third_addr", out_if.araddr === 32'h1000_0000);
    step();
    in0_if.arvalid = 0; in1_if.arvalid = 0;
    out_if.rvalid = 1;
    step();
    clr();
    #1;

    in1_if.awvalid = 1; in1_if.awaddr = 32'h0F00_0004;
    in1_if.awlen = 1; in1_if.awid = 4'h3;
    in1_if.wvalid = 1; in1_if.wdata = 64'hD0;
    in1_if.wstrb = 8'hF0; in1_if.wlast = 0;
    out_if.wready = 1;
    step();
    chk("t3_awvalid", out_if.awvalid === 1'b1);
    chk("t3_awaddr", out_if.awaddr === 32'h0F00_0004);
    chk("t3_wvalid_early", out_if.wvalid === 1'b0);
    chk("t3_wready_early", in1_if.wready === 1'b0);
    step();
    chk("t3_wvalid_hold", out_if.wvalid === 1'b0);
    out_if.awready = 1;
    #1;
    chk("t3_awready", in1_if.awready === 1'b1);
    step();
    in1_if.awvalid = 0; out_if.awready = 0;
    #1;
    chk("t3_wvalid", out_if.wvalid === 1'b1);
    chk("t3_wstrb", out_if.wstrb === 8'hF0);
    chk("t3_wdata0", out_if.wdata === 64'hD0);
    chk("t3_wready", in1_if.wready === 1'b1);
    step();
    in1_if.wdata = 64'hD1; in1_if.wlast = 1;
    #1;
    chk("t3_wdata1", out_if.wdata === 64'hD1);
    chk("t3_wlast", out_if.wlast === 1'b1);
    step();
    in1_if.wvalid = 0; in1_if.wlast = 0;
    out_if.bvalid = 1; out_if.bresp = 2'b10; out_if.bid = 4'h3;
    in1_if.bready = 1;
    #1;
    chk("t3_bvalid", in1_if.bvalid === 1'b1);
    chk("t3_bresp", in1_if.bresp === 2'b10);
    chk("t3_bid", in1_if.bid === 4'h3);
    chk("t3_bready", out_if.bready === 1'b1);
    chk("t3_in0_bvalid", in0_if.bvalid === 1'b0);
    step();
    clr();
    #1;

    in1_if.arvalid = 1; in1_if.araddr = 32'h3000_0000;
    in1_if.awvalid = 1; in1_if.awaddr = 32'h4000_0000;
    in1_if.rready = 1;
    step();
    chk("t4_arvalid", out_if.arvalid === 1'b1);
    chk("t4_awvalid_ar", out_if.awvalid === 1'b0);
    out_if.arready = 1;
    step();
    in1_if.arvalid = 0; out_if.arready = 0;
    out_if.rvalid = 1; out_if.rlast = 1;
    #1;
    chk("t4_awvalid_r", out_if.awvalid === 1'b0);
    chk("t4_rvalid", in1_if.rvalid === 1'b1);
    step();
    out_if.rvalid = 0; out_if.rlast = 0;
    #1;
    chk("t4_awvalid_gap", out_if.awvalid === 1'b0);
    step();
    chk("t4_awvalid", out_if.awvalid === 1'b1);
    chk("t4_awaddr", out_if.awaddr === 32'h4000_0000);
    out_if.awready = 1;
    step();
    in1_if.awvalid = 0; out_if.awready = 0;
    in1_if.wvalid = 1; in1_if.wlast = 1; out_if.wready = 1;
    step();
    in1_if.wvalid = 0; in1_if.wlast = 0;
    out_if.bvalid = 1; in1_if.bready = 1;
    step();
    clr();
    #1;
    chk("t4_idle", dut.state_q === 3'd0);

    in0_if.arvalid = 1; in0_if.araddr = 32'h5000_0000;
    in0_if.arlen = 3;
    step();
    out_if.arready = 1;
    step();
    in0_if.arvalid = 0; out_if.arready = 0;
    k = 0;
    for (int i = 0; i < 9; i++) begin
      out_if.rvalid = rv_v[i];
      out_if.rdata = 64'h100 + 64'(k);
      out_if.rlast = (k == 3);
      in0_if.rready = rr_v[i];
      #1;
      chk("t5_rready", out_if.rready === rr_v[i]);
      chk("t5_rvalid", in0_if.rvalid === rv_v[i]);
      if (rv_v[i])
        chk("t5_rdata", in0_if.rdata === 64'h100 + 64'(k));
      step();
      if (rv_v[i] && rr_v[i])
        k++;
    end
    out_if.rvalid = 0; out_if.rlast = 0;
    #1;
    chk("t5_idle", dut.state_q === 3'd0);
    chk("t5_last", dut.last_q === 1'b0);

    clr();
    in0_if.arvalid = 1; in0_if.araddr = 32'h7000_0000;
    in0_if.arlen = 3;
    step();
    out_if.arready = 1;
    step();
    in0_if.arvalid = 0; out_if.arready = 0;
    in0_if.rready = 1; out_if.rvalid = 1;
    step();
    step();
    reset = 0;
    step();
    reset = 1;
    #1;
    chk("t6_state", dut.state_q === 3'd0);
    chk("t6_out_rready", out_if.rready === 1'b0);
    chk("t6_in0_rvalid", in0_if.rvalid === 1'b0);
    chk("t6_out_arvalid", out_if.arvalid === 1'b0);
    chk("t6_out_wvalid", out_if.wvalid === 1'b0);
    out_if.rvalid = 0;
    in1_if.arvalid = 1; in1_if.araddr = 32'h6000_0000;
    step();
    chk("t6_arvalid", out_if.arvalid === 1'b1);
    chk("t6_araddr", out_if.araddr === 32'h6000_0000);
    chk("t6_grant", dut.grant_q === 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
